// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: captures ADC IQ samples during a capture window, sends one FFT config beat,
// then streams the samples to the FFT in FRAME_LEN-sample frames with tlast, zero-padding the
// final partial frame. A small first-word-fall-through FIFO absorbs FFT back-pressure.
module fft_frame_feeder #(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CFG_WIDTH  = 24
) (
    input  logic                 clk_245,
    input  logic                 clk_245_rst,

    input  logic [31:0]          adc_data_iq,
    input  logic                 adc_data_valid,
    input  logic                 adc_enable,
    input  logic [CFG_WIDTH-1:0] fft_config_word,

    output logic [CFG_WIDTH-1:0] s_axis_fft_config_tdata,
    output logic                 s_axis_fft_config_tvalid,
    input  logic                 s_axis_fft_config_tready,

    output logic [31:0]          s_axis_fft_data_tdata,
    output logic                 s_axis_fft_data_tvalid,
    input  logic                 s_axis_fft_data_tready,
    output logic                 s_axis_fft_data_tlast,

    output logic [15:0]          frame_count,
    output logic                 overflow,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W:0]   FIFO_FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StConfig,
        StCapture,
        StPad
    } state_t;

    state_t state_q, state_d;

    logic [CFG_WIDTH-1:0] cfg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [15:0]          frame_q;
    logic                 ovf_q;

    logic [31:0]          fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W:0]       fill_q;

    logic fifo_empty;
    logic fifo_full;
    logic win_start;
    logic wr_req;
    logic wr_en;
    logic rd_en;
    logic drop;
    logic data_hs;
    logic cnt_at_last;

    // Shared handshake and FIFO control decode
    always_comb begin
        fifo_empty  = (fill_q == '0);
        fifo_full   = (fill_q == FIFO_FULL_LVL);
        win_start   = (state_q == StIdle) && adc_enable;
        cnt_at_last = (cnt_q == CNT_LAST);
        // Reads only happen while the FIFO head is being presented in CAPTURE.
        rd_en       = (state_q == StCapture) && !fifo_empty && s_axis_fft_data_tready;
        wr_req      = adc_enable && adc_data_valid &&
                      ((state_q == StConfig) || (state_q == StCapture));
        // A full FIFO still accepts a sample when the head leaves in the same cycle.
        wr_en       = wr_req && (!fifo_full || rd_en);
        drop        = wr_req && !wr_en;
        data_hs     = s_axis_fft_data_tvalid && s_axis_fft_data_tready;
    end

    // FSM state register
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (adc_enable) begin
                    state_d = StConfig;
                end
            end
            StConfig: begin
                if (s_axis_fft_config_tready) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Leave only once drained; a non-zero counter means a partial frame is open.
                if (!adc_enable && fifo_empty) begin
                    state_d = (cnt_q == '0) ? StIdle : StPad;
                end
            end
            StPad: begin
                if (s_axis_fft_data_tready && cnt_at_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // AXI-stream and status outputs
    always_comb begin
        s_axis_fft_config_tdata  = cfg_q;
        s_axis_fft_config_tvalid = (state_q == StConfig);
        s_axis_fft_data_tvalid   = 1'b0;
        s_axis_fft_data_tdata    = '0;
        unique case (state_q)
            StCapture: begin
                s_axis_fft_data_tvalid = !fifo_empty;
                if (!fifo_empty) begin
                    s_axis_fft_data_tdata = fifo_mem[rd_ptr_q];
                end
            end
            StPad: begin
                s_axis_fft_data_tvalid = 1'b1;
            end
            default: begin
                s_axis_fft_data_tvalid = 1'b0;
            end
        endcase
        s_axis_fft_data_tlast = s_axis_fft_data_tvalid && cnt_at_last;
        frame_count           = frame_q;
        overflow              = ovf_q;
        busy                  = (state_q != StIdle);
    end

    // Config word latch, taken when a capture window opens
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            cfg_q <= '0;
        end else if (win_start) begin
            cfg_q <= fft_config_word;
        end
    end

    // Sticky overflow flag, cleared at each window start
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            ovf_q <= 1'b0;
        end else if (win_start) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    // Sample-in-frame counter; wraps naturally since FRAME_LEN is a power of two
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            cnt_q <= '0;
        end else if (win_start) begin
            cnt_q <= '0;
        end else if (data_hs) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Completed-frame counter, wraps at 16 bits
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            frame_q <= '0;
        end else if (data_hs && cnt_at_last) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk_245 or posedge clk_245_rst) begin
        if (clk_245_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the fill level is zero
    always_ff @(posedge clk_245) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= adc_data_iq;
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: directed capture windows; a queue model of the expected FFT data
// and config streams is checked on every cycle, plus literal end-of-window expectations.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

    localparam int FL = 8;
    localparam int FD = 16;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   adc_iq = '0;
    logic          adc_valid = 1'b0;
    logic          adc_enable = 1'b0;
    logic [CW-1:0] cfg_word = '0;
    logic [CW-1:0] cfg_tdata;
    logic          cfg_tvalid;
    logic          cfg_tready = 1'b1;
    logic [31:0]   d_tdata;
    logic          d_tvalid;
    logic          d_tready = 1'b1;
    logic          d_tlast;
    logic [15:0]   frame_count;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Expected-stream model
    logic [31:0]   exp_data [$];
    logic [CW-1:0] exp_cfg [$];
    int            beat_idx = 0;
    int            model_frames = 0;
    int            win_n = 0;
    int            tr_mode = 1;  // 0: tready low, 1: tready high, 2: toggle each cycle

    logic          stall_prev = 1'b0;
    logic [31:0]   prev_data = '0;
    logic          prev_last = 1'b0;

    fft_frame_feeder #(
        .FRAME_LEN (FL),
        .FIFO_DEPTH(FD),
        .CFG_WIDTH (CW)
    ) dut (
        .clk_245                 (clk),
        .clk_245_rst             (rst),
        .adc_data_iq             (adc_iq),
        .adc_data_valid          (adc_valid),
        .adc_enable              (adc_enable),
        .fft_config_word         (cfg_word),
        .s_axis_fft_config_tdata (cfg_tdata),
        .s_axis_fft_config_tvalid(cfg_tvalid),
        .s_axis_fft_config_tready(cfg_tready),
        .s_axis_fft_data_tdata   (d_tdata),
        .s_axis_fft_data_tvalid  (d_tvalid),
        .s_axis_fft_data_tready  (d_tready),
        .s_axis_fft_data_tlast   (d_tlast),
        .frame_count             (frame_count),
        .overflow                (overflow),
        .busy                    (busy)
    );

    always #2 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Data tready pattern generator
    always @(posedge clk) begin
        #1;
        if (tr_mode == 0) d_tready = 1'b0;
        else if (tr_mode == 1) d_tready = 1'b1;
        else d_tready = ~d_tready;
    end

    // Compare process: checks DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            exp_data.delete();
            exp_cfg.delete();
            beat_idx     = 0;
            model_frames = 0;
            stall_prev   = 1'b0;
        end else begin
            check("frame_count", 64'(frame_count), 64'(model_frames[15:0]));
            if (cfg_tvalid && cfg_tready) begin
                if (exp_cfg.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg_beat: got unexpected beat %0h expected none", cfg_tdata);
                end else begin
                    check("cfg_tdata", 64'(cfg_tdata), 64'(exp_cfg.pop_front()));
                end
            end
            if (stall_prev) begin
                check("stall_hold", {31'd0, d_tvalid, d_tlast, d_tdata},
                      {31'd0, 1'b1, prev_last, prev_data});
            end
            if (d_tvalid && d_tready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_beat: got unexpected beat %0h expected none", d_tdata);
                end else begin
                    check("d_tdata", 64'(d_tdata), 64'(exp_data.pop_front()));
                    check("d_tlast", 64'(d_tlast), 64'(beat_idx == FL - 1));
                    if (beat_idx == FL - 1) model_frames++;
                    beat_idx = (beat_idx + 1) % FL;
                end
            end
            stall_prev = d_tvalid && !d_tready;
            prev_data  = d_tdata;
            prev_last  = d_tlast;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic [CW-1:0] cw);
        cfg_word   = cw;
        adc_enable = 1'b1;
        adc_valid  = 1'b0;
        exp_cfg.push_back(cw);
        win_n = 0;
        step();
    endtask

    task automatic send(input logic [31:0] s, input bit keep);
        adc_iq    = s;
        adc_valid = 1'b1;
        if (keep) begin
            exp_data.push_back(s);
            win_n++;
        end
        step();
    endtask

    task automatic idle_cycle();
        adc_valid = 1'b0;
        step();
    endtask

    task automatic end_window();
        adc_enable = 1'b0;
        adc_valid  = 1'b0;
        repeat ((FL - (win_n % FL)) % FL) exp_data.push_back(32'd0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_drained"}, 64'(exp_data.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("reset_outputs", {cfg_tdata, cfg_tvalid, d_tdata, d_tvalid, d_tlast},
              64'd0);
        check("reset_status", {frame_count, overflow, busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // 1: 16 back-to-back samples, two full frames
        start_window(24'h000C0B);
        for (int i = 0; i < 16; i++) send(32'(i), 1'b1);
        end_window();
        wait_idle("t1");
        check("t1_frames", 64'(frame_count), 64'd2);
        check("t1_overflow", 64'(overflow), 64'd0);

        // 2: 11 samples, 5 zero-pad beats
        start_window(24'h123456);
        for (int i = 0; i < 11; i++) send(32'hA000_0000 + 32'(i), 1'b1);
        end_window();
        wait_idle("t2");
        check("t2_frames", 64'(frame_count), 64'd4);

        // 3: FFT stalled while 20 samples arrive; last 4 dropped
        tr_mode = 0;
        start_window(24'h0000AA);
        for (int i = 0; i < 20; i++) send(32'hB000_0000 + 32'(i), i < 16);
        check("t3_overflow_set", 64'(overflow), 64'd1);
        tr_mode = 1;
        end_window();
        wait_idle("t3");
        check("t3_frames", 64'(frame_count), 64'd6);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // 4: config held off for 5 cycles; samples buffered meanwhile
        cfg_tready = 1'b0;
        start_window(24'h0000BB);
        check("t4_overflow_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < 5; i++) send(32'hC000_0000 + 32'(i), 1'b1);
        check("t4_cfg_pending", 64'(cfg_tvalid), 64'd1);
        cfg_tready = 1'b1;
        end_window();
        wait_idle("t4");
        check("t4_frames", 64'(frame_count), 64'd7);
        check("t4_overflow", 64'(overflow), 64'd0);

        // 5: toggling tready, samples every other cycle
        tr_mode = 2;
        start_window(24'h0000CC);
        for (int i = 0; i < 24; i++) begin
            send(32'hD000_0000 + 32'(i), 1'b1);
            idle_cycle();
        end
        end_window();
        wait_idle("t5");
        tr_mode = 1;
        check("t5_frames", 64'(frame_count), 64'd10);
        check("t5_overflow", 64'(overflow), 64'd0);

        // 6: asynchronous reset mid-frame, then a fresh window
        start_window(24'h000ABC);
        for (int i = 0; i < 5; i++) send(32'hE000_0000 + 32'(i), 1'b1);
        repeat (3) idle_cycle();
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        #1;
        rst = 1'b1;
        #0.5;
        check("t6_rst_outputs", {cfg_tdata, cfg_tvalid, d_tdata, d_tvalid, d_tlast},
              64'd0);
        check("t6_rst_status", {frame_count, overflow, busy}, 64'd0);
        step();
        step();
        rst = 1'b0;
        start_window(24'h000DEF);
        for (int i = 0; i < 8; i++) send(32'hF000_0000 + 32'(i), 1'b1);
        end_window();
        wait_idle("t6");
        check("t6_frames", 64'(frame_count), 64'd1);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
Name: fft_frame_feeder

Overview:
Sits downstream of the chirp loopback ADC sample path in the clk_245 domain and feeds the xfft core. Captures 32-bit IQ samples ({I[15:0],Q[15:0]}) while adc_enable is high. Issues one FFT config beat per capture window, then streams samples onto the FFT data channel in fixed-length frames with tlast. Zero-pads the final partial frame, and buffers samples through FFT back-pressure in a small FIFO.

Parameters:
FRAME_LEN, 1024, samples per FFT frame; power of 2, 8..65536.
FIFO_DEPTH, 16, internal sample buffer depth; power of 2, >=4.
CFG_WIDTH, 24, width of the FFT config word.

Ports:
clk_245  in  1  sample clock, 245.76 MHz.
clk_245_rst  in  1  reset, asynchronous assert, active-high.
adc_data_iq  in  32  ADC sample {I,Q}.
adc_data_valid  in  1  sample strobe.
adc_enable  in  1  capture window, level.
fft_config_word  in  CFG_WIDTH  FFT config; latched at window start.
s_axis_fft_config_tdata  out  CFG_WIDTH  config payload.
s_axis_fft_config_tvalid  out  1  config valid.
s_axis_fft_config_tready  in  1  config ready.
s_axis_fft_data_tdata  out  32  sample to FFT.
s_axis_fft_data_tvalid  out  1  data valid.
s_axis_fft_data_tready  in  1  data ready.
s_axis_fft_data_tlast  out  1  last sample of frame.
frame_count  out  16  completed frames (tlast handshakes); wraps at 0xFFFF->0.
overflow  out  1  sticky: a sample was dropped because the FIFO was full.
busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async): state IDLE; FIFO flushed; sample counter 0. All outputs 0, including frame_count and overflow. Applies mid-frame with no partial output.
- States:
  - IDLE: adc_enable=1 -> CONFIG. On entry to CONFIG: latch fft_config_word into config tdata, clear overflow.
  - CONFIG: config tvalid=1, tdata held stable. On config tvalid&tready -> CAPTURE (tvalid drops the next cycle).
  - CAPTURE: data tvalid = FIFO not empty; tdata = FIFO head (first-word fall-through). When adc_enable=0 and FIFO empty: sample counter==0 -> IDLE, else -> PAD.
  - PAD: tvalid=1, tdata=0. On the tlast handshake -> IDLE.
- FIFO write: adc_enable & adc_data_valid, in CONFIG or CAPTURE.
  - Write is accepted if the FIFO is not full, or a read handshake happens the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - Samples arriving in IDLE or PAD are ignored and do not set overflow.
- Latency: a sample written at cycle N is presentable at tdata at N+1 at the earliest, and only in CAPTURE.
- Sample counter: log2(FRAME_LEN) bits, increments on each data handshake (tvalid&tready), wraps to 0 after FRAME_LEN-1.
- tlast = tvalid & (counter==FRAME_LEN-1), in both CAPTURE and PAD.
- frame_count increments on each tlast handshake.
- tdata/tvalid/tlast are held stable while tvalid=1 and tready=0 (AXI rule).
- adc_enable falling in CONFIG: config beat still completes. The FIFO content then drains; any partial frame is padded.
- adc_enable re-rising during PAD: ignored until IDLE. IDLE re-enters CONFIG on the next cycle if adc_enable is still high.
- Frame alignment: each window starts at counter 0. A window whose length is a multiple of FRAME_LEN produces no padding.

Test Plan:
1. FRAME_LEN=8; config word 0x000C0B; both treadys=1; 16 consecutive samples 0x00000000..0x0000000F -> one config beat 0x000C0B; 16 data beats in order; tlast on beats 8 and 16; frame_count=2; busy low afterwards; overflow=0.
2. FRAME_LEN=8; window of 11 samples -> 11 data beats then 5 zero beats; tlast on beat 16; frame_count=2; state returns to IDLE.
3. FIFO_DEPTH=16; data tready=0 while 20 samples arrive, then tready=1 -> first 16 samples emitted in order; samples 17..20 lost; overflow=1 until next window start.
4. config tready held 0 for 5 cycles while 5 samples arrive -> config accepted on cycle 6; all 5 samples then emitted with no loss; overflow=0.
5. data tready toggling 1/0 each cycle; adc_data_valid every 2nd cycle; 24 samples, FRAME_LEN=8 -> no drops; tdata/tlast stable during stalls; frame_count=3.
6. clk_245_rst asserted mid-frame (counter=5) -> all outputs 0 asynchronously. After release with adc_enable=1: new config beat, counter restarts at 0, first tlast after 8 beats.
